screenmode_switcher: RTL
========================

SCREENMODE_SWITCHER -- requirements
Module: screenmode_switcher

Interface
REQ-001 Parameter NUM_MODES, default 4, number of programmable mode slots (power of two, 2..8).
REQ-002 Parameter HOLD_CYCLES, default 8, cycles vt_reset_n is held low per switch (minimum 4).
REQ-003 Parameter TIMEOUT_BITS, default 22, width of the frame-wait timeout counter.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mode_req  in  1  single-cycle request to switch to mode_sel.
REQ-007 mode_sel  in  log2(NUM_MODES)  requested mode slot.
REQ-008 frame_stb  in  1  frame-start pulse from the timing generator.
REQ-009 cfg_wr  in  1  table write strobe.
REQ-010 cfg_addr  in  log2(NUM_MODES)+4  {slot, field}; field 0..8 = clkdiv, hbstart, hsstart, hsstop, htotal, vbstart, vsstart, vsstop, vtotal; 9 = polarities; 10..15 ignored.
REQ-011 cfg_data  in  12  field value; clkdiv uses [3:0]; polarities use [0]=hpolarity, [1]=vpolarity.
REQ-012 timings  out  screenmode_timings  active timing set driving the generator.
REQ-013 vt_reset_n  out  1  active-low reset to the timing generator.
REQ-014 cur_mode  out  log2(NUM_MODES)  slot currently applied.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.
REQ-016 mode_ack  out  1  one-cycle pulse when a switch completes.

Function
REQ-017 FSM states: IDLE, WAIT_FRAME, HOLD; encoding free.
REQ-018 IDLE + mode_req: latch mode_sel into target; next state WAIT_FRAME; busy high the following cycle.
REQ-019 mode_req while busy is ignored; no queueing.
REQ-020 WAIT_FRAME: on frame_stb, or when the timeout counter reaches all-ones, enter HOLD; counter clears on WAIT_FRAME entry.
REQ-021 HOLD entry cycle: timings loads table[target], cur_mode loads target, vt_reset_n driven low.
REQ-022 HOLD lasts exactly HOLD_CYCLES cycles with vt_reset_n low; on exit vt_reset_n goes high, mode_ack pulses for one cycle, state returns to IDLE.
REQ-023 Switching to the slot already in cur_mode performs the full sequence (used to re-apply edited values).
REQ-024 cfg_wr is accepted in every state: table[slot][field] updates next edge; timings changes only at HOLD entry.
REQ-025 cfg_wr and HOLD entry on the same edge for the target slot: the copy uses the pre-write value.
REQ-026 cfg_wr in IDLE coincident with mode_req: the write is visible to the later copy.
REQ-027 cfg_addr field 10..15: write discarded; no table change.
REQ-028 Table fields are 12 bits except clkdiv (4) and polarities (2); upper cfg_data bits ignored.
REQ-029 frame_stb outside WAIT_FRAME has no effect.

Reset
REQ-030 During reset: every table slot = {clkdiv 1, hbstart 640, hsstart 656, hsstop 752, htotal 800, vbstart 480, vsstart 490, vsstop 492, vtotal 525, hpolarity 0, vpolarity 0}; timings = same; cur_mode 0; target 0; busy 1; mode_ack 0; vt_reset_n 0.
REQ-031 On reset release the FSM is in HOLD with the hold counter cleared; it completes HOLD_CYCLES cycles, pulses mode_ack, enters IDLE.
REQ-032 Reset asserted mid-switch aborts it immediately; all state returns to REQ-030 values.

Verification
REQ-033 Release reset -> vt_reset_n low 8 cycles, mode_ack one pulse, busy falls, timings.htotal=800.
REQ-034 Write slot1 htotal=1056, vtotal=628; mode_req mode_sel=1; frame_stb 50 cycles later -> vt_reset_n low 8 cycles from next edge, timings.htotal=1056, cur_mode=1, one mode_ack.
REQ-035 mode_req with frame_stb never pulsed, TIMEOUT_BITS=6 -> HOLD entered after 63 WAIT_FRAME cycles, switch completes.
REQ-036 Second mode_req while busy -> ignored; cur_mode reflects first request only; exactly one mode_ack.
REQ-037 cfg_wr slot1 hbstart=800 on the HOLD-entry edge of a switch to slot1 -> timings.hbstart keeps old value; re-request slot1 -> 800 applied.
REQ-038 Assert reset during HOLD of a switch to slot2 -> cur_mode=0, table reloaded with defaults, vt_reset_n low, no mode_ack until post-reset hold completes.

Source files
------------

// File: rtl/screenmode_pkg.sv
// Shared types for the screen-mode switcher: one complete
// timing set as handed to the video timing generator.
package screenmode_pkg;

    typedef struct packed {
        logic [3:0]  clkdiv;
        logic [11:0] hbstart;
        logic [11:0] hsstart;
        logic [11:0] hsstop;
        logic [11:0] htotal;
        logic [11:0] vbstart;
        logic [11:0] vsstart;
        logic [11:0] vsstop;
        logic [11:0] vtotal;
        logic        hpolarity;
        logic        vpolarity;
    } screenmode_timings;

    // 640x480@60 style default loaded into every slot at reset
    localparam screenmode_timings TIMINGS_DEFAULT = '{
        clkdiv:    4'd1,
        hbstart:   12'd640,
        hsstart:   12'd656,
        hsstop:    12'd752,
        htotal:    12'd800,
        vbstart:   12'd480,
        vsstart:   12'd490,
        vsstop:    12'd492,
        vtotal:    12'd525,
        hpolarity: 1'b0,
        vpolarity: 1'b0
    };

endpackage

// File: rtl/screenmode_switcher.sv
// Programmable mode table plus a switch sequencer that waits for a
// frame boundary, then applies the new timings under generator reset.
module screenmode_switcher
    import screenmode_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int TIMEOUT_BITS = 22,
    localparam int SW = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_req,
    input  logic [SW-1:0]     mode_sel,
    input  logic              frame_stb,
    input  logic              cfg_wr,
    input  logic [SW+3:0]     cfg_addr,
    input  logic [11:0]       cfg_data,
    output screenmode_timings timings,
    output logic              vt_reset_n,
    output logic [SW-1:0]     cur_mode,
    output logic              busy,
    output logic              mode_ack
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    // Leaving on the count before all-ones bounds the wait to 2^N-1 cycles
    localparam logic [TIMEOUT_BITS-1:0] TMO_LAST =
        {TIMEOUT_BITS{1'b1}} - TIMEOUT_BITS'(1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           target_q, target_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic                    load_tim;
    logic                    ack_d;
    screenmode_timings       table_q [NUM_MODES];

    logic [SW-1:0] cfg_slot;
    logic [3:0]    cfg_field;

    assign cfg_slot   = cfg_addr[SW+3:4];
    assign cfg_field  = cfg_addr[3:0];
    assign busy       = (state_q != IDLE);
    assign vt_reset_n = (state_q != HOLD);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        tmo_d    = tmo_q;
        hold_d   = hold_q;
        load_tim = 1'b0;
        ack_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mode_req) begin
                    target_d = mode_sel;
                    tmo_d    = '0;
                    state_d  = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_stb || tmo_q == TMO_LAST) begin
                    state_d  = HOLD;
                    hold_d   = '0;
                    load_tim = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HOLD;
            target_q <= '0;
            tmo_q    <= '0;
            hold_q   <= '0;
            mode_ack <= 1'b0;
            cur_mode <= '0;
            timings  <= TIMINGS_DEFAULT;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            tmo_q    <= tmo_d;
            hold_q   <= hold_d;
            mode_ack <= ack_d;
            if (load_tim) begin
                // Reads the table before any same-edge write lands
                timings  <= table_q[target_q];
                cur_mode <= target_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MODES; i++) begin
                table_q[i] <= TIMINGS_DEFAULT;
            end
        end else if (cfg_wr) begin
            case (cfg_field)
                4'd0: table_q[cfg_slot].clkdiv  <= cfg_data[3:0];
                4'd1: table_q[cfg_slot].hbstart <= cfg_data;
                4'd2: table_q[cfg_slot].hsstart <= cfg_data;
                4'd3: table_q[cfg_slot].hsstop  <= cfg_data;
                4'd4: table_q[cfg_slot].htotal  <= cfg_data;
                4'd5: table_q[cfg_slot].vbstart <= cfg_data;
                4'd6: table_q[cfg_slot].vsstart <= cfg_data;
                4'd7: table_q[cfg_slot].vsstop  <= cfg_data;
                4'd8: table_q[cfg_slot].vtotal  <= cfg_data;
                4'd9: begin
                    table_q[cfg_slot].hpolarity <= cfg_data[0];
                    table_q[cfg_slot].vpolarity <= cfg_data[1];
                end
                default: ;
            endcase
        end
    end

endmodule
